diff_decoder: RTL



---
 rtl/diff_decoder_if.sv | 22 ++
 rtl/diff_decoder.sv | 98 +++++++++
 2 files changed

// File: rtl/diff_decoder_if.sv
// Handshake bundle for diff_decoder: accumulated-value input stream, resync strobe
// and the recovered-sample output stream.
interface diff_decoder_if;
    logic        SYNC;
    logic        IN_VALID;
    logic        IN_READY;
    logic [16:0] IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] OUT;
    logic        OVF;

    modport master (
        output SYNC, IN_VALID, IN, OUT_READY,
        input  IN_READY, OUT_VALID, OUT, OVF
    );

    modport slave (
        input  SYNC, IN_VALID, IN, OUT_READY,
        output IN_READY, OUT_VALID, OUT, OVF
    );
endinterface

// File: rtl/diff_decoder.sv
// Comb differentiator OUT = IN(n) - IN(n-M) mod 2^17; DIFF_SAT_EN adds 16-bit saturation + OVF.
// Latency: 1 cycle from accept to OUT_VALID; the first M accepts after reset/SYNC only prime history.
// Backpressure: IN_READY = !OUT_VALID || OUT_READY (one-entry output register, zero-bubble).
module diff_decoder #(
    parameter int M     = 1,
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input logic          CLK,
    input logic          NRST,
    diff_decoder_if.slave bus
);
    typedef enum logic {PRIME, RUN} state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic [IN_W-1:0]     h [M];
    logic                out_vld_q;
    logic [OUT_W-1:0]    out_q;
    logic [IN_W-1:0]     d17;
    logic [OUT_W-1:0]    out_d;
    logic                accept;
    logic                xfer;

    assign bus.IN_READY  = !out_vld_q || bus.OUT_READY;
    assign accept        = bus.IN_VALID && bus.IN_READY;
    assign xfer          = out_vld_q && bus.OUT_READY;
    assign bus.OUT_VALID = out_vld_q;
    assign bus.OUT       = out_q;

    // Modular subtraction: accumulator wrap between the two samples cancels out.
    assign d17 = bus.IN - h[M-1];

`ifdef DIFF_SAT_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d   = d17[IN_W-1] ^ d17[IN_W-2];
    assign out_d   = !ovf_d ? d17[OUT_W-1:0] :
                     (d17[IN_W-1] ? 16'h8000 : 16'h7FFF);
    assign bus.OVF = ovf_q;
`else
    logic unused_sign;

    assign unused_sign = d17[IN_W-1];
    assign out_d       = d17[OUT_W-1:0];
    assign bus.OVF     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state     <= PRIME;
            cnt       <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
`ifdef DIFF_SAT_EN
            ovf_q     <= 1'b0;
`endif
            for (int k = 0; k < M; k++) begin
                h[k] <= '0;
            end
        end else if (bus.SYNC) begin
            // Resync wins over a same-cycle accept; that sample is dropped.
            state     <= PRIME;
            cnt       <= '0;
            out_vld_q <= 1'b0;
            for (int k = 0; k < M; k++) begin
                h[k] <= '0;
            end
        end else begin
            if (xfer) begin
                out_vld_q <= 1'b0;
            end
            if (accept) begin
                h[0] <= bus.IN;
                for (int k = 1; k < M; k++) begin
                    h[k] <= h[k-1];
                end
                case (state)
                    PRIME: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'(M - 1)) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        out_vld_q <= 1'b1;
                        out_q     <= out_d;
`ifdef DIFF_SAT_EN
                        ovf_q     <= ovf_d;
`endif
                    end
                    default: state <= PRIME;
                endcase
            end
        end
    end
endmodule
